// File: rtl/sr04_pkg.sv
// Shared types and constants for the HC-SR04 echo emulator.
package sr04_pkg;

    // Responder FSM states
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StTrigHi  = 3'd1,
        StBurst   = 3'd2,
        StEchoHi  = 3'd3,
        StHoldoff = 3'd4
    } sr04_state_e;

    // Distance (mm) to round-trip time (us): t = (d * K) >> SHIFT, roughly 2*d / 340 m/s
    localparam int unsigned SR04_K     = 6024;
    localparam int unsigned SR04_SHIFT = 10;

    // Default timing
    localparam int unsigned DEF_CLK_FREQ_MHZ  = 50;
    localparam int unsigned DEF_TRIG_MIN_US   = 10;
    localparam int unsigned DEF_ECHO_DELAY_US = 250;
    localparam int unsigned DEF_DIST_MAX_MM   = 4000;
    localparam int unsigned DEF_TIMEOUT_US    = 38000;
    localparam int unsigned DEF_HOLDOFF_US    = 10000;

    // ECHO width in us for a latched distance. Zero distance and anything past the
    // maximum range both report the no-target timeout. The 29-bit product holds the
    // worst case 65535 * 6024; keeping bits [25:10] truncates without rounding.
    function automatic logic [15:0] sr04_echo_width(
        input logic [15:0] dist_mm,
        input logic [15:0] dist_max_mm,
        input logic [15:0] timeout_us
    );
        logic [28:0] prod;
        prod = 29'(dist_mm) * 29'(SR04_K);
        if ((dist_mm == 16'd0) || (dist_mm > dist_max_mm)) begin
            return timeout_us;
        end
        return 16'(prod >> SR04_SHIFT);
    endfunction

endpackage

// File: rtl/sr04_us_tick.sv
// Microsecond prescaler: one-cycle Tick each time the 0..CLK_FREQ_MHZ-1 count wraps.
// Clr restarts the count so an interval begun on the cleared cycle lasts exactly
// N * CLK_FREQ_MHZ cycles for N ticks.
module sr04_us_tick
    import sr04_pkg::*;
#(
    parameter int unsigned CLK_FREQ_MHZ = DEF_CLK_FREQ_MHZ
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic Clr,
    output logic Tick
);

    localparam int unsigned CW = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CW'(CLK_FREQ_MHZ - 1));

    // Tick is not gated by Clr: the FSM derives Clr from a transition that a tick may cause
    assign Tick = w_wrap;

    // Prescaler count with synchronous clear
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_cnt <= '0;
        end else if (Clr || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hc_sr04_echo_emulator.sv
// HC-SR04 responder: accepts a TRIG pulse, waits the burst time, then drives ECHO high
// for the round-trip time of the distance latched when the trigger was accepted.
module hc_sr04_echo_emulator
    import sr04_pkg::*;
#(
    parameter int unsigned CLK_FREQ_MHZ  = DEF_CLK_FREQ_MHZ,
    parameter int unsigned TRIG_MIN_US   = DEF_TRIG_MIN_US,
    parameter int unsigned ECHO_DELAY_US = DEF_ECHO_DELAY_US,
    parameter int unsigned DIST_MAX_MM   = DEF_DIST_MAX_MM,
    parameter int unsigned TIMEOUT_US    = DEF_TIMEOUT_US,
    parameter int unsigned HOLDOFF_US    = DEF_HOLDOFF_US
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        En,
    input  logic        TRIG,
    input  logic [15:0] Dist_mm,
    output logic        ECHO,
    output logic        Busy,
    output logic        Trig_Err,
    output logic        Echo_Done,
    output logic [15:0] Echo_Width_us
);

    // TRIG synchroniser and edge register
    logic r_trig_meta;
    logic r_trig_sync;
    logic r_trig_prev;
    logic w_trig_rise;
    logic w_trig_fall;

    // FSM and timing
    sr04_state_e r_state;
    sr04_state_e w_state_d;
    logic        w_tick;
    logic        w_clr;
    logic [15:0] r_us;
    logic [15:0] r_width;
    logic [15:0] w_width_calc;
    logic        w_accept;
    logic        w_err;
    logic        w_done;

    // Registered outputs
    logic r_echo;
    logic r_busy;
    logic r_trig_err;
    logic r_echo_done;

    // Two-flop synchroniser for the asynchronous TRIG pin, plus the edge-detect stage
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_trig_meta <= 1'b0;
            r_trig_sync <= 1'b0;
            r_trig_prev <= 1'b0;
        end else begin
            r_trig_meta <= TRIG;
            r_trig_sync <= r_trig_meta;
            r_trig_prev <= r_trig_sync;
        end
    end

    assign w_trig_rise = r_trig_sync & ~r_trig_prev;
    assign w_trig_fall = ~r_trig_sync & r_trig_prev;

    assign w_width_calc = sr04_echo_width(Dist_mm, 16'(DIST_MAX_MM), 16'(TIMEOUT_US));

    // Every state entry restarts both the prescaler and the interval counter
    assign w_clr = (w_state_d != r_state);

    sr04_us_tick #(
        .CLK_FREQ_MHZ (CLK_FREQ_MHZ)
    ) u_us_tick (
        .CLK  (CLK),
        .RSTn (RSTn),
        .Clr  (w_clr),
        .Tick (w_tick)
    );

    // Next-state decode and single-cycle event strobes
    always_comb begin
        w_state_d = r_state;
        w_accept  = 1'b0;
        w_err     = 1'b0;
        w_done    = 1'b0;
        if (!En) begin
            // Disable abandons any cycle in progress without reporting completion
            w_state_d = StIdle;
        end else begin
            unique case (r_state)
                StIdle: begin
                    // Only a rise starts a cycle; a TRIG already high is ignored
                    if (w_trig_rise) begin
                        w_state_d = StTrigHi;
                    end
                end
                StTrigHi: begin
                    if (w_trig_fall) begin
                        if (r_us >= 16'(TRIG_MIN_US)) begin
                            w_accept  = 1'b1;
                            w_state_d = StBurst;
                        end else begin
                            w_err     = 1'b1;
                            w_state_d = StIdle;
                        end
                    end
                end
                StBurst: begin
                    if (w_tick && (r_us == 16'(ECHO_DELAY_US - 1))) begin
                        w_state_d = StEchoHi;
                    end
                end
                StEchoHi: begin
                    if (w_tick && (r_us == (r_width - 16'd1))) begin
                        w_done    = 1'b1;
                        w_state_d = StHoldoff;
                    end
                end
                StHoldoff: begin
                    if (w_tick && (r_us == 16'(HOLDOFF_US - 1))) begin
                        w_state_d = StIdle;
                    end
                end
                default: begin
                    w_state_d = StIdle;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Microsecond interval counter; saturates at the minimum width while TRIG is high
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_us <= '0;
        end else if (w_clr) begin
            r_us <= '0;
        end else if (w_tick && (r_state != StIdle)) begin
            if (r_state == StTrigHi) begin
                if (r_us < 16'(TRIG_MIN_US)) begin
                    r_us <= r_us + 16'd1;
                end
            end else begin
                r_us <= r_us + 16'd1;
            end
        end
    end

    // Width latch: later Dist_mm changes cannot disturb a pulse in progress
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_width <= '0;
        end else if (w_accept) begin
            r_width <= w_width_calc;
        end
    end

    // Outputs registered from the next state so they track the state register exactly
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_echo      <= 1'b0;
            r_busy      <= 1'b0;
            r_trig_err  <= 1'b0;
            r_echo_done <= 1'b0;
        end else begin
            r_echo      <= (w_state_d == StEchoHi);
            r_busy      <= (w_state_d != StIdle);
            r_trig_err  <= w_err;
            r_echo_done <= w_done;
        end
    end

    assign ECHO          = r_echo;
    assign Busy          = r_busy;
    assign Trig_Err      = r_trig_err;
    assign Echo_Done     = r_echo_done;
    assign Echo_Width_us = r_width;

endmodule

// File: tb/tb_hc_sr04_echo_emulator.sv
// Directed bench for hc_sr04_echo_emulator, run with a scaled-down timebase
// (2 cycles/us, short delays) so every scenario completes in a few thousand cycles.
module tb_hc_sr04_echo_emulator;

    localparam int unsigned F_MHZ   = 2;
    localparam int unsigned TMIN    = 10;
    localparam int unsigned EDLY    = 25;
    localparam int unsigned DMAX    = 200;
    localparam int unsigned TOUT    = 500;
    localparam int unsigned HOLD    = 300;
    // TRIG fall to ECHO rise: 3 sync/edge cycles plus the burst delay
    localparam int          LAT     = 3 + EDLY * F_MHZ;
    localparam int          HOLD_CY = HOLD * F_MHZ;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        En;
    logic        TRIG;
    logic [15:0] Dist_mm;
    logic        ECHO;
    logic        Busy;
    logic        Trig_Err;
    logic        Echo_Done;
    logic [15:0] Echo_Width_us;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    hc_sr04_echo_emulator #(
        .CLK_FREQ_MHZ  (F_MHZ),
        .TRIG_MIN_US   (TMIN),
        .ECHO_DELAY_US (EDLY),
        .DIST_MAX_MM   (DMAX),
        .TIMEOUT_US    (TOUT),
        .HOLDOFF_US    (HOLD)
    ) dut (
        .CLK           (CLK),
        .RSTn          (RSTn),
        .En            (En),
        .TRIG          (TRIG),
        .Dist_mm       (Dist_mm),
        .ECHO          (ECHO),
        .Busy          (Busy),
        .Trig_Err      (Trig_Err),
        .Echo_Done     (Echo_Done),
        .Echo_Width_us (Echo_Width_us)
    );

    initial forever #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Pulse counters for the one-cycle strobes
    always @(negedge CLK) begin
        if (Echo_Done === 1'b1) done_cnt <= done_cnt + 1;
        if (Trig_Err === 1'b1)  err_cnt  <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // which: 0 = ECHO, 1 = Busy. Returns the cycle stamp at the first negedge showing val.
    task automatic wait_for(input int which, input logic val, input int limit,
                            input string tag, output int stamp);
        logic seen;
        seen  = 1'b0;
        stamp = cyc;
        for (int i = 0; i < limit; i++) begin
            @(negedge CLK);
            if (((which == 0) ? ECHO : Busy) === val) begin
                seen  = 1'b1;
                stamp = cyc;
                break;
            end
        end
        check({tag, " reached"}, 32'(seen), 32'd1);
    endtask

    task automatic trig_pulse(input int n, output int t_fall);
        @(posedge CLK);
        #1 TRIG = 1'b1;
        repeat (n) @(posedge CLK);
        #1 TRIG = 1'b0;
        t_fall = cyc;
    endtask

    // Full accepted cycle: latency, ECHO width, Echo_Done, reported width, holdoff length
    task automatic run_cycle(input logic [15:0] d, input int exp_us, input string tag);
        int tf, tr, tl, ti;
        Dist_mm = d;
        trig_pulse(24, tf);
        wait_for(0, 1'b1, 200, {tag, " rise"}, tr);
        check({tag, " latency"}, 32'(tr - tf), 32'(LAT));
        check({tag, " busy"}, 32'(Busy), 32'd1);
        wait_for(0, 1'b0, 5000, {tag, " fall"}, tl);
        check({tag, " echo cycles"}, 32'(tl - tr), 32'(exp_us * int'(F_MHZ)));
        check({tag, " echo_done"}, 32'(Echo_Done), 32'd1);
        check({tag, " width_us"}, 32'(Echo_Width_us), 32'(exp_us));
        wait_for(1, 1'b0, 1000, {tag, " idle"}, ti);
        check({tag, " holdoff"}, 32'(ti - tl), 32'(HOLD_CY));
    endtask

    initial begin
        int tf, tr, tl, ti, d0, e0;
        logic echo_seen;

        RSTn    = 1'b0;
        En      = 1'b1;
        TRIG    = 1'b0;
        Dist_mm = 16'd0;
        #1;
        check("rst echo", 32'(ECHO), 32'd0);
        check("rst busy", 32'(Busy), 32'd0);
        check("rst trig_err", 32'(Trig_Err), 32'd0);
        check("rst echo_done", 32'(Echo_Done), 32'd0);
        check("rst width", 32'(Echo_Width_us), 32'd0);
        repeat (3) @(negedge CLK);
        RSTn = 1'b1;
        repeat (2) @(negedge CLK);

        // Normal cycle: 100 mm -> 602400 >> 10 = 588 us
        d0 = done_cnt;
        run_cycle(16'd100, 588, "d100");
        check("d100 one done", 32'(done_cnt - d0), 32'd1);

        // Short trigger: rejected with one Trig_Err
        e0        = err_cnt;
        echo_seen = 1'b0;
        trig_pulse(10, tf);
        repeat (20) begin
            @(negedge CLK);
            if (ECHO === 1'b1) echo_seen = 1'b1;
        end
        check("short err count", 32'(err_cnt - e0), 32'd1);
        check("short no echo", 32'(echo_seen), 32'd0);
        check("short busy", 32'(Busy), 32'd0);
        check("short width held", 32'(Echo_Width_us), 32'd588);

        // Range limits: 0 and max+1 time out; 200 mm -> 1204800 >> 10 = 1176 us
        run_cycle(16'd0, int'(TOUT), "d0");
        run_cycle(16'(DMAX + 1), int'(TOUT), "dmax+1");
        run_cycle(16'(DMAX), 1176, "dmax");

        // Retriggers during ECHO_HI and mid-HOLDOFF are ignored; 150 mm -> 882 us
        Dist_mm = 16'd150;
        trig_pulse(24, tf);
        wait_for(0, 1'b1, 200, "rt rise", tr);
        repeat (100) @(negedge CLK);
        trig_pulse(24, d0);
        wait_for(0, 1'b0, 5000, "rt fall", tl);
        check("rt echo cycles", 32'(tl - tr), 32'(882 * F_MHZ));
        check("rt width_us", 32'(Echo_Width_us), 32'd882);
        repeat (HOLD_CY / 2) @(negedge CLK);
        trig_pulse(24, d0);
        wait_for(1, 1'b0, 1000, "rt idle", ti);
        check("rt holdoff", 32'(ti - tl), 32'(HOLD_CY));
        // Immediately after holdoff a new trigger is accepted
        run_cycle(16'd150, 882, "after hold");

        // Dist_mm change during BURST does not alter the pulse
        Dist_mm = 16'd100;
        trig_pulse(24, tf);
        repeat (10) @(negedge CLK);
        Dist_mm = 16'd200;
        wait_for(0, 1'b1, 200, "latch rise", tr);
        check("latch latency", 32'(tr - tf), 32'(LAT));
        wait_for(0, 1'b0, 5000, "latch fall", tl);
        check("latch echo cycles", 32'(tl - tr), 32'(588 * F_MHZ));
        check("latch width_us", 32'(Echo_Width_us), 32'd588);
        wait_for(1, 1'b0, 1000, "latch idle", ti);

        // En low mid-ECHO: ECHO and Busy drop on the next edge, no Echo_Done
        Dist_mm = 16'd100;
        trig_pulse(24, tf);
        wait_for(0, 1'b1, 200, "en rise", tr);
        repeat (20) @(negedge CLK);
        d0 = done_cnt;
        @(posedge CLK);
        #1 En = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("en echo", 32'(ECHO), 32'd0);
        check("en busy", 32'(Busy), 32'd0);
        repeat (10) @(negedge CLK);
        check("en no done", 32'(done_cnt - d0), 32'd0);
        check("en width held", 32'(Echo_Width_us), 32'd588);
        En = 1'b1;
        repeat (5) @(negedge CLK);

        // Asynchronous reset mid-ECHO
        trig_pulse(24, tf);
        wait_for(0, 1'b1, 200, "rst rise", tr);
        repeat (20) @(negedge CLK);
        #2 RSTn = 1'b0;
        #1;
        check("async echo", 32'(ECHO), 32'd0);
        check("async busy", 32'(Busy), 32'd0);
        check("async trig_err", 32'(Trig_Err), 32'd0);
        check("async echo_done", 32'(Echo_Done), 32'd0);
        check("async width", 32'(Echo_Width_us), 32'd0);
        @(negedge CLK);
        RSTn = 1'b1;
        repeat (3) @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
